// File: rtl/msg_assembler.sv
// Multi-beat AXI-Stream packet assembler: compacts kept lanes into a message buffer and
// presents good packets on a valid/ready port. Optional stats ports behind MSG_ASM_STATS_EN.
module msg_assembler #(
  parameter int MAX_MSG_BYTES = 32,
  parameter int DATA_BYTES    = 8,
  parameter int LEN_WIDTH     = $clog2(MAX_MSG_BYTES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic                       s_tlast,
  input  logic                       s_tuser,
  input  logic [DATA_BYTES-1:0]      s_tkeep,
  input  logic [8*DATA_BYTES-1:0]    s_tdata,
  output logic                       msg_valid,
  input  logic                       msg_ready,
  output logic [8*MAX_MSG_BYTES-1:0] msg_data,
  output logic [LEN_WIDTH-1:0]       msg_len,
  output logic                       msg_error
`ifdef MSG_ASM_STATS_EN
  ,
  output logic [15:0]                msg_count,
  output logic [15:0]                drop_count
`endif
);

  localparam int SUM_W      = $clog2(MAX_MSG_BYTES + DATA_BYTES + 1);
  localparam int KEEP_CNT_W = $clog2(DATA_BYTES + 1);
  localparam int IDX_W      = (MAX_MSG_BYTES > 1) ? $clog2(MAX_MSG_BYTES) : 1;

  typedef enum logic [1:0] {ACCUM, DROP, HOLD} state_e;

  state_e                             state_q, state_d;
  logic [LEN_WIDTH-1:0]               count_q, count_d;
  logic [MAX_MSG_BYTES-1:0][7:0]      msg_buf_q, msg_buf_d;
  logic [MAX_MSG_BYTES-1:0][7:0]      msg_data_q, msg_data_d;
  logic [LEN_WIDTH-1:0]               msg_len_q, msg_len_d;
  logic                               msg_error_q, msg_error_d;

  logic                               beat_fire;
  logic [KEEP_CNT_W-1:0]              keep_cnt;
  logic [SUM_W-1:0]                   sum;
  logic [SUM_W-1:0]                   wr_pos;
  logic                               overflow;
  logic [MAX_MSG_BYTES-1:0][7:0]      merged;

  assign s_tready  = (state_q != HOLD);
  assign msg_valid = (state_q == HOLD);
  assign beat_fire = s_tvalid && s_tready;
  assign msg_data  = msg_data_q;
  assign msg_len   = msg_len_q;
  assign msg_error = msg_error_q;

  // Compaction: kept lanes land in ascending order starting at the current byte count.
  // NOTE: wr_pos is a running accumulator inside one evaluation, so it uses blocking '='
  // and is given a value before the loop so no latch is inferred.
  always_comb begin
    keep_cnt = '0;
    wr_pos   = SUM_W'(count_q);
    merged   = msg_buf_q;
    for (int i = 0; i < DATA_BYTES; i++) begin
      keep_cnt = keep_cnt + KEEP_CNT_W'(s_tkeep[i]);
      if (s_tkeep[i]) begin
        if (wr_pos < SUM_W'(MAX_MSG_BYTES)) merged[wr_pos[IDX_W-1:0]] = s_tdata[8*i +: 8];
        wr_pos = wr_pos + SUM_W'(1);
      end
    end
    sum      = SUM_W'(count_q) + SUM_W'(keep_cnt);
    overflow = (sum > SUM_W'(MAX_MSG_BYTES));
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    msg_buf_d   = msg_buf_q;
    msg_data_d  = msg_data_q;
    msg_len_d   = msg_len_q;
    msg_error_d = 1'b0;
    case (state_q)
      ACCUM: begin
        if (beat_fire) begin
          if (s_tuser || overflow) begin
            // Buffer is cleared on the first bad beat so unused bytes stay zero.
            msg_buf_d = '0;
            count_d   = '0;
            if (s_tlast) msg_error_d = 1'b1;
            else         state_d     = DROP;
          end else if (s_tlast) begin
            msg_buf_d = '0;
            count_d   = '0;
            if (sum != '0) begin
              msg_data_d = merged;
              msg_len_d  = LEN_WIDTH'(sum);
              state_d    = HOLD;
            end
          end else begin
            msg_buf_d = merged;
            count_d   = LEN_WIDTH'(sum);
          end
        end
      end
      DROP: begin
        if (beat_fire && s_tlast) begin
          msg_error_d = 1'b1;
          state_d     = ACCUM;
        end
      end
      HOLD: begin
        if (msg_ready) begin
          msg_buf_d = '0;
          count_d   = '0;
          state_d   = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      count_q     <= '0;
      msg_buf_q   <= '0;
      msg_data_q  <= '0;
      msg_len_q   <= '0;
      msg_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      msg_buf_q   <= msg_buf_d;
      msg_data_q  <= msg_data_d;
      msg_len_q   <= msg_len_d;
      msg_error_q <= msg_error_d;
    end
  end

`ifdef MSG_ASM_STATS_EN
  logic [15:0] msg_count_q, msg_count_d;
  logic [15:0] drop_count_q, drop_count_d;

  always_comb begin
    msg_count_d  = msg_count_q;
    drop_count_d = drop_count_q;
    if (msg_valid && msg_ready && (msg_count_q != 16'hFFFF)) msg_count_d = msg_count_q + 16'd1;
    if (msg_error_q && (drop_count_q != 16'hFFFF))           drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      msg_count_q  <= msg_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign msg_count  = msg_count_q;
  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_msg_assembler.sv
// Self-checking bench for msg_assembler: table-driven packets with a scoreboard of expected
// messages/errors, plus hand sequences for sparse lanes, backpressure and mid-packet reset.
module tb_msg_assembler;
  localparam int MAXB = 32;
  localparam int DB   = 8;
  localparam int LW   = $clog2(MAXB + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            s_tvalid, s_tready, s_tlast, s_tuser;
  logic [DB-1:0]   s_tkeep;
  logic [8*DB-1:0] s_tdata;
  logic            msg_valid, msg_ready, msg_error;
  logic [8*MAXB-1:0] msg_data;
  logic [LW-1:0]   msg_len;
`ifdef MSG_ASM_STATS_EN
  logic [15:0]     msg_count, drop_count;
`endif

  always #5 clk = ~clk;

  msg_assembler #(.MAX_MSG_BYTES(MAXB), .DATA_BYTES(DB)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .s_tkeep(s_tkeep), .s_tdata(s_tdata),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .msg_len(msg_len), .msg_error(msg_error)
`ifdef MSG_ASM_STATS_EN
    , .msg_count(msg_count), .drop_count(drop_count)
`endif
  );

  typedef struct packed {
    logic [2:0]       nbeats;
    logic [5:0][7:0]  keep;     // keep[b] is beat b
    logic [5:0]       user;     // user[b] is beat b
    logic [63:0]      data0;    // beat 0 data; later beats are random
    logic             exp_err;
    logic [5:0]       exp_len;
  } vec_t;

  typedef struct packed {
    logic         is_err;
    logic [5:0]   len;
    logic [255:0] data;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [47:0] keep, input logic [5:0] user,
                              input logic [63:0] d0, input logic err, input int len);
    vec_t v;
    v.nbeats  = 3'(n);
    v.keep    = keep;
    v.user    = user;
    v.data0   = d0;
    v.exp_err = err;
    v.exp_len = 6'(len);
    return v;
  endfunction

  // Scoreboard consumer: every error pulse and every handshake must match the next entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (msg_error) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_error: msg_error=1 with nothing expected");
        end else begin
          e = sb.pop_front();
          check("sb_kind_err", e.is_err, 1'b1);
        end
      end
      if (msg_valid && msg_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_msg: handshake len=%0d with nothing expected", msg_len);
        end else begin
          e = sb.pop_front();
          check("sb_kind_msg", e.is_err, 1'b0);
          check("sb_len", msg_len, e.len);
          check("sb_data", msg_data, e.data);
        end
      end
    end
  end

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic u, input logic l);
    int waited = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tuser = u; s_tlast = l;
    @(negedge clk);
    while (!s_tready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("tready_timeout", s_tready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"}, s_tready, 1'b1);
    check({tag, "_valid"},  msg_valid, 1'b0);
    check({tag, "_len"},    msg_len, '0);
    check({tag, "_data"},   msg_data, '0);
    check({tag, "_error"},  msg_error, 1'b0);
  endtask

  task automatic send(input vec_t v);
    logic [5:0][63:0] d;
    exp_t e;
    int   pos = 0;
    for (int b = 0; b < 6; b++) d[b] = (b == 0) ? v.data0 : {$urandom, $urandom};
    e.data = '0;
    for (int b = 0; b < int'(v.nbeats); b++)
      for (int i = 0; i < 8; i++)
        if (v.keep[b][i]) begin
          if (pos < MAXB) e.data[pos*8 +: 8] = d[b][i*8 +: 8];
          pos++;
        end
    e.is_err = v.exp_err;
    e.len    = v.exp_len;
    if (v.exp_err || v.exp_len != 0) sb.push_back(e);
    for (int b = 0; b < int'(v.nbeats); b++)
      drive_beat(d[b], v.keep[b], v.user[b], b == int'(v.nbeats) - 1);
    s_tvalid = 1'b0;
    if (v.exp_err) begin
      check("err_pulse", msg_error, 1'b1);
      check("no_valid_on_err", msg_valid, 1'b0);
    end else if (v.exp_len != 0) begin
      check("valid_latency", msg_valid, 1'b1);
      check("no_err_on_msg", msg_error, 1'b0);
      check("len_at_valid", msg_len, v.exp_len);
    end else begin
      check("silent_no_valid", msg_valid, 1'b0);
      check("silent_no_err", msg_error, 1'b0);
    end
    @(posedge clk); #1;
    check("err_one_cycle", msg_error, 1'b0);
    check("valid_one_cycle", msg_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[12];
    exp_t e1, e2;
    logic [63:0] d;

    vecs[0]  = mk(3, {8'h00, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'hFF}, 6'b000000, 64'h0807060504030201, 1'b0, 20);
    vecs[1]  = mk(1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}, 6'b000000, 64'h8877665544332211, 1'b0, 4);
    vecs[2]  = mk(4, {8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 6'b000010, 64'h1111111111111111, 1'b1, 0);
    vecs[3]  = mk(1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF}, 6'b000000, 64'hDEADBEEFCAFEF00D, 1'b0, 8);
    vecs[4]  = mk(5, {8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 6'b000000, 64'h2222222222222222, 1'b1, 0);
    vecs[5]  = mk(4, {8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 6'b000000, 64'h0123456789ABCDEF, 1'b0, 32);
    vecs[6]  = mk(1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 6'b000000, 64'h3333333333333333, 1'b0, 0);
    vecs[7]  = mk(2, {8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00}, 6'b000000, 64'h4444444444444444, 1'b0, 4);
    vecs[8]  = mk(5, {8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 6'b000000, 64'h5555555555555555, 1'b1, 0);
    vecs[9]  = mk(5, {8'h00, 8'h0F, 8'hF0, 8'hFF, 8'hFF, 8'hFF}, 6'b000000, 64'hA1B2C3D4E5F60718, 1'b0, 32);
    vecs[10] = mk(2, {8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF}, 6'b000010, 64'h6666666666666666, 1'b1, 0);
    vecs[11] = mk(2, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF}, 6'b000010, 64'h7777777777777777, 1'b1, 0);

    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    s_tkeep = '0; s_tdata = '0; msg_ready = 1'b1;
    #1;
    check_reset_outputs("reset");
`ifdef MSG_ASM_STATS_EN
    check("reset_msg_count", msg_count, 16'd0);
    check("reset_drop_count", drop_count, 16'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 12; k++) send(vecs[k]);

    // Sparse lanes, checked against literal bytes.
    e1.is_err = 1'b0; e1.len = 6'd4; e1.data = 256'h88663311;
    sb.push_back(e1);
    drive_beat(64'h8877665544332211, 8'b1010_0101, 1'b0, 1'b1);
    s_tvalid = 1'b0;
    check("sparse_valid", msg_valid, 1'b1);
    check("sparse_len", msg_len, 6'd4);
    check("sparse_data", msg_data, 256'h88663311);
    @(posedge clk); #1;

    // Backpressure: a second packet is offered during HOLD and must wait.
    msg_ready = 1'b0;
    d = {$urandom, $urandom};
    e1.is_err = 1'b0; e1.len = 6'd8; e1.data = {192'd0, d};
    sb.push_back(e1);
    drive_beat(d, 8'hFF, 1'b0, 1'b1);
    d = {$urandom, $urandom};
    e2.is_err = 1'b0; e2.len = 6'd4; e2.data = {224'd0, d[31:0]};
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = 8'h0F; s_tuser = 1'b0; s_tlast = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("bp_tready_low", s_tready, 1'b0);
      check("bp_valid_high", msg_valid, 1'b1);
      check("bp_len_stable", msg_len, e1.len);
      check("bp_data_stable", msg_data, e1.data);
      @(posedge clk); #1;
    end
    sb.push_back(e2);
    msg_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_tready", s_tready, 1'b1);
    check("bp_release_valid", msg_valid, 1'b0);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    check("bp_next_valid", msg_valid, 1'b1);
    check("bp_next_len", msg_len, 6'd4);
    @(posedge clk); #1;

    // Reset asserted asynchronously during beat 2 of a 3-beat packet.
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0);
    s_tvalid = 1'b1; s_tdata = {$urandom, $urandom}; s_tkeep = 8'hFF; s_tlast = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midpkt_reset");
    s_tvalid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
`ifdef MSG_ASM_STATS_EN
    check("rst2_msg_count", msg_count, 16'd0);
    check("rst2_drop_count", drop_count, 16'd0);
`endif
    d = {$urandom, $urandom};
    e1.is_err = 1'b0; e1.len = 6'd4; e1.data = {224'd0, d[31:0]};
    sb.push_back(e1);
    drive_beat(d, 8'h0F, 1'b0, 1'b1);
    s_tvalid = 1'b0;
    check("post_reset_valid", msg_valid, 1'b1);
    check("post_reset_len", msg_len, 6'd4);
    check("post_reset_data", msg_data, e1.data);
    @(posedge clk); #1;
`ifdef MSG_ASM_STATS_EN
    check("stats_msg_count", msg_count, 16'd1);
    check("stats_drop_count", drop_count, 16'd0);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
